// File: rtl/timer_control_fsm_pkg.sv
// Shared state encoding and default timing constants for the countdown-timer control stage.
package timer_pkg;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DEBOUNCE_CYCLES = 500_000;      // 10 ms
    localparam int ALARM_CYCLES    = 150_000_000;  // 3 s
    localparam int BLINK_CYCLES    = 12_500_000;   // 0.25 s half-period

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_ALARM   = 2'd3
    } state_t;

endpackage

// File: rtl/timer_control_fsm_if.sv
// Timer-facing bundle: expiry input from the timer, control and status outputs to it and the board.
interface timer_control_fsm_if;
    import timer_pkg::*;

    logic   expire_pulse;
    logic   timer_enable;
    logic   timer_reset;
    state_t state;
    logic   running_led;
    logic   alarm_led;

    modport master (
        input  expire_pulse,
        output timer_enable, timer_reset, state, running_led, alarm_led
    );

    modport slave (
        output expire_pulse,
        input  timer_enable, timer_reset, state, running_led, alarm_led
    );

endinterface

// File: rtl/timer_control_fsm_debouncer.sv
// Synchronizes and debounces one active-low push-button; one-clock pulse on each accepted press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = timer_pkg::DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic pressed_level,
    output logic press_pulse
);
    import timer_pkg::*;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_n;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          sync_pressed;

    assign sync_pressed = ~sync_n[1];

    // armed stays low until the key is seen released, so a key held through reset gives no event
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_n        <= '0;
            cnt           <= '0;
            pressed_level <= 1'b0;
            press_pulse   <= 1'b0;
            armed         <= 1'b0;
        end else begin
            sync_n      <= {sync_n[0], key_n};
            press_pulse <= 1'b0;
            if (sync_n[1])
                armed <= 1'b1;
            if (sync_pressed == pressed_level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt           <= '0;
                pressed_level <= sync_pressed;
                press_pulse   <= sync_pressed & armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_control_fsm.sv
// Start/pause/clear control FSM for the countdown timer, with a timed blinking alarm on expiry.
module timer_control_fsm #(
    parameter int DEBOUNCE_CYCLES = timer_pkg::DEBOUNCE_CYCLES,
    parameter int ALARM_CYCLES    = timer_pkg::ALARM_CYCLES,
    parameter int BLINK_CYCLES    = timer_pkg::BLINK_CYCLES
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                key_start_pause,
    input  logic                key_clear,
    timer_control_fsm_if.master tmr
);
    import timer_pkg::*;

    localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    state_t        state_q, nxt_state;
    logic [AW-1:0] alarm_cnt, nxt_alarm_cnt;
    logic [BW-1:0] blink_cnt, nxt_blink_cnt;
    logic          alarm_led_q, nxt_alarm_led;
    logic          enable_q, reset_q, run_led_q;
    logic          sp_pulse, clr_pulse, sp_level, clr_level;
    logic          unused_levels;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sp (
        .clock(clock), .resetn(resetn), .key_n(key_start_pause),
        .pressed_level(sp_level), .press_pulse(sp_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clock(clock), .resetn(resetn), .key_n(key_clear),
        .pressed_level(clr_level), .press_pulse(clr_pulse)
    );

    assign unused_levels = sp_level ^ clr_level;

    always_comb begin
        nxt_state     = state_q;
        nxt_alarm_cnt = '0;
        nxt_blink_cnt = '0;
        nxt_alarm_led = 1'b0;
        case (state_q)
            ST_IDLE:    if (sp_pulse) nxt_state = ST_RUNNING;
            ST_RUNNING: if (tmr.expire_pulse) nxt_state = ST_ALARM;
                        else if (sp_pulse)    nxt_state = ST_PAUSED;
            ST_PAUSED:  if (sp_pulse) nxt_state = ST_RUNNING;
            ST_ALARM:   if (sp_pulse || alarm_cnt == AW'(ALARM_CYCLES - 1)) nxt_state = ST_IDLE;
            default:    nxt_state = ST_IDLE;
        endcase
        if (clr_pulse)
            nxt_state = ST_IDLE;

        // alarm/blink counters start from zero on ALARM entry, LED starts lit
        if (nxt_state == ST_ALARM) begin
            if (state_q != ST_ALARM) begin
                nxt_alarm_led = 1'b1;
            end else begin
                nxt_alarm_cnt = alarm_cnt + 1'b1;
                if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                    nxt_alarm_led = ~alarm_led_q;
                end else begin
                    nxt_blink_cnt = blink_cnt + 1'b1;
                    nxt_alarm_led = alarm_led_q;
                end
            end
        end
    end

    // outputs are decoded from the next state so they change on the same edge as state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            alarm_cnt   <= '0;
            blink_cnt   <= '0;
            alarm_led_q <= 1'b0;
            enable_q    <= 1'b0;
            reset_q     <= 1'b1;
            run_led_q   <= 1'b0;
        end else begin
            state_q     <= nxt_state;
            alarm_cnt   <= nxt_alarm_cnt;
            blink_cnt   <= nxt_blink_cnt;
            alarm_led_q <= nxt_alarm_led;
            enable_q    <= (nxt_state == ST_RUNNING);
            reset_q     <= (nxt_state == ST_IDLE);
            run_led_q   <= (nxt_state == ST_RUNNING);
        end
    end

    assign tmr.state        = state_q;
    assign tmr.timer_enable = enable_q;
    assign tmr.timer_reset  = reset_q;
    assign tmr.running_led  = run_led_q;
    assign tmr.alarm_led    = alarm_led_q;

endmodule

// File: tb/tb_timer_control_fsm.sv
// Scoreboard bench for timer_control_fsm: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_timer_control_fsm;

    logic clock = 1'b0;
    logic resetn;
    logic key_start_pause;
    logic key_clear;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // expected vector layout: {state[1:0], timer_enable, timer_reset, running_led, alarm_led}
    localparam logic [5:0] O_IDLE  = 6'b00_0100;
    localparam logic [5:0] O_RUN   = 6'b01_1010;
    localparam logic [5:0] O_PAUSE = 6'b10_0000;
    localparam logic [5:0] O_AHI   = 6'b11_0001;
    localparam logic [5:0] O_ALO   = 6'b11_0000;

    typedef struct {
        int         at;
        logic [5:0] val;
        string      nm;
    } exp_t;

    exp_t sb[$];

    timer_control_fsm_if tif ();

    timer_control_fsm #(
        .DEBOUNCE_CYCLES(4), .ALARM_CYCLES(20), .BLINK_CYCLES(5)
    ) dut (
        .clock(clock), .resetn(resetn),
        .key_start_pause(key_start_pause), .key_clear(key_clear),
        .tmr(tif)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic expect_at(input int at, input string nm, input logic [5:0] val);
        exp_t e;
        int   idx;
        e.at = at; e.val = val; e.nm = nm;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].at > at) begin idx = i; break; end
        sb.insert(idx, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input bit clr, input logic [5:0] pre, input logic [5:0] post, input string nm);
        int b0;
        b0 = cyc;
        expect_at(b0 + 6, {nm, "_pre"}, pre);
        expect_at(b0 + 7, nm, post);
        if (clr) key_clear = 1'b0; else key_start_pause = 1'b0;
        tick(6);
        key_clear = 1'b1; key_start_pause = 1'b1;
        tick(8);
    endtask

    always @(negedge clock) begin
        logic [5:0] outv;
        exp_t       e;
        outv = {tif.state, tif.timer_enable, tif.timer_reset, tif.running_led, tif.alarm_led};
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.at < cyc) begin
                n_bad++;
                $display("FAIL %s: check at cycle %0d was skipped (now %0d)", e.nm, e.at, cyc);
            end else if (outv !== e.val) begin
                n_bad++;
                $display("FAIL %s: cycle %0d got %b expected %b", e.nm, cyc, outv, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        resetn = 1'b0; key_start_pause = 1'b1; key_clear = 1'b1; tif.expire_pulse = 1'b0;
        tick(2);
        b = cyc;
        expect_at(b, "reset_vals", O_IDLE);
        expect_at(b + 10, "idle_10", O_IDLE);
        tick(1);
        resetn = 1'b1;
        tick(11);

        // short bounces never accumulate enough stable cycles
        b = cyc;
        expect_at(b + 12, "bounce_none", O_IDLE);
        key_start_pause = 1'b0; tick(2);
        key_start_pause = 1'b1; tick(1);
        key_start_pause = 1'b0; tick(2);
        key_start_pause = 1'b1; tick(14);

        // long hold: pulse in cycle 6, state in cycle 7, single transition
        b = cyc;
        expect_at(b + 6, "press_lat_pre", O_IDLE);
        expect_at(b + 7, "press_lat", O_RUN);
        expect_at(b + 20, "press_once", O_RUN);
        key_start_pause = 1'b0; tick(20);
        key_start_pause = 1'b1; tick(10);

        press(1'b0, O_RUN, O_PAUSE, "pause");
        press(1'b0, O_PAUSE, O_RUN, "resume");

        // expire and start_pause pulse in the same cycle; then full alarm blink and timeout
        b = cyc;
        expect_at(b + 6, "simul_pre", O_RUN);
        expect_at(b + 7, "alarm_entry", O_AHI);
        expect_at(b + 11, "blink_hi1_end", O_AHI);
        expect_at(b + 12, "blink_lo1", O_ALO);
        expect_at(b + 16, "blink_lo1_end", O_ALO);
        expect_at(b + 17, "blink_hi2", O_AHI);
        expect_at(b + 22, "blink_lo2", O_ALO);
        expect_at(b + 26, "alarm_last", O_ALO);
        expect_at(b + 27, "alarm_timeout", O_IDLE);
        key_start_pause = 1'b0; tick(6);
        tif.expire_pulse = 1'b1; key_start_pause = 1'b1; tick(1);
        tif.expire_pulse = 1'b0; tick(25);

        // multi-cycle expire gives one transition; clear leaves the alarm
        press(1'b0, O_IDLE, O_RUN, "run2");
        b = cyc;
        expect_at(b + 1, "expire_multi", O_AHI);
        expect_at(b + 3, "expire_multi_hold", O_AHI);
        tif.expire_pulse = 1'b1; tick(3);
        tif.expire_pulse = 1'b0;
        press(1'b1, O_ALO, O_IDLE, "clear_alarm");

        // start_pause acknowledges the alarm
        press(1'b0, O_IDLE, O_RUN, "run3");
        b = cyc;
        expect_at(b + 1, "expire_single", O_AHI);
        tif.expire_pulse = 1'b1; tick(1);
        tif.expire_pulse = 1'b0;
        press(1'b0, O_ALO, O_IDLE, "alarm_ack");

        // clear while paused
        press(1'b0, O_IDLE, O_RUN, "run4");
        press(1'b0, O_RUN, O_PAUSE, "pause4");
        press(1'b1, O_PAUSE, O_IDLE, "clear_paused");

        // asynchronous reset mid-cycle in PAUSED with the key held across release
        press(1'b0, O_IDLE, O_RUN, "run5");
        press(1'b0, O_RUN, O_PAUSE, "pause5");
        b = cyc;
        expect_at(b, "async_reset", O_IDLE);
        key_start_pause = 1'b0;
        #2 resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        b = cyc;
        expect_at(b + 15, "held_no_event", O_IDLE);
        tick(15);
        key_start_pause = 1'b1;
        tick(10);
        press(1'b0, O_IDLE, O_RUN, "repress");

        tick(3);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: check at cycle %0d never reached", e.nm, e.at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_control_fsm.md
Name: timer_control_fsm

Overview:
- Upstream and downstream control stage for the 5-hex conventional countdown timer (2:00.00 -> 0:00.00).
- Debounces the start/pause and clear push-buttons, and drives the timer's enable and reset inputs.
- Consumes the timer's expiry pulse and runs a timed, blinking alarm before returning to idle.
- Sits between the board KEY inputs and the timer instance in the top level.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks needed before a button level is accepted (10 ms at 50 MHz).
- ALARM_CYCLES, 150000000: clocks spent in ALARM before the automatic return to IDLE (3 s).
- BLINK_CYCLES, 12500000: half-period of the alarm_led blink (0.25 s).

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- key_start_pause  in  1  raw button, active-low, asynchronous to clock.
- key_clear  in  1  raw button, active-low, asynchronous to clock.
- expire_pulse  in  1  timer out_pulse; active-high, one clock or longer.
- timer_enable  out  1  drives the timer enable input.
- timer_reset  out  1  drives the timer reset input; active-high, reloads 2:00.00.
- state  out  2  current state, encoded IDLE=0, RUNNING=1, PAUSED=2, ALARM=3.
- running_led  out  1  high in RUNNING.
- alarm_led  out  1  blinks in ALARM.

Behaviour:
- Clock and reset: one clock. resetn is asynchronous and active-low. All flops clear immediately when resetn=0.
- Reset values:
  - state=IDLE, timer_enable=0, timer_reset=1, running_led=0, alarm_led=0.
  - Debouncers reset to "released", with counters at 0.
  - Alarm and blink counters reset to 0.
- Button path (per key):
  - 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized level differs from the debounced level, and clears whenever they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A press pulse is emitted for exactly one clock on the released->pressed transition only. Release generates no event.
  - Latency: with a raw key held low from the clock edge at cycle 0, the press pulse is high in cycle DEBOUNCE_CYCLES+2. The state register updates at the next edge, cycle DEBOUNCE_CYCLES+3.
- Outputs are registered and decoded from state:
  - IDLE: timer_reset=1, timer_enable=0. Holding reset for the whole state keeps the display at 2:00.00.
  - RUNNING: timer_reset=0, timer_enable=1, running_led=1.
  - PAUSED: timer_reset=0, timer_enable=0. The displayed value is frozen.
  - ALARM: timer_reset=0, timer_enable=0. alarm_led toggles every BLINK_CYCLES, starting high on entry.
- Transitions (priority: clear > expire > start_pause):
  - Any state + clear press -> IDLE. This clears the alarm and blink counters.
  - IDLE + start_pause -> RUNNING.
  - RUNNING + expire_pulse -> ALARM. The alarm counter loads 0.
  - RUNNING + start_pause -> PAUSED.
  - PAUSED + start_pause -> RUNNING.
  - ALARM + start_pause -> IDLE (acknowledge).
  - ALARM when alarm counter = ALARM_CYCLES-1 -> IDLE.
- Ignored inputs: expire_pulse outside RUNNING. A multi-cycle expire_pulse causes one transition only.
- Simultaneous events in RUNNING: expire and start_pause in the same cycle -> ALARM.
- Counter widths: each counter is $clog2 of its parameter. Counters saturate-free; they clear on every state entry.
- Reset mid-operation: any state returns to IDLE asynchronously. A button held through reset release must be released and re-pressed before it produces an event.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding constants ST_IDLE, ST_RUNNING, ST_PAUSED, ST_ALARM;
  - default timing constants (CLK_HZ, DEBOUNCE_CYCLES, ALARM_CYCLES, BLINK_CYCLES).
- One sub-module, button_debouncer (parameter DEBOUNCE_CYCLES; ports clock, resetn, key_n, pressed_level, press_pulse), instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, ALARM_CYCLES=20, BLINK_CYCLES=5):
- Reset then idle 10 cycles -> state=0, timer_reset=1, timer_enable=0, alarm_led=0.
- key_start_pause low from cycle 0, held 20 cycles -> press pulse in cycle 6, state=1 at cycle 7, timer_enable=1. Exactly one transition.
- Bounce: key_start_pause low 2 cycles, high 1, low 2, then high -> no press pulse, state stays 0.
- RUNNING, press start_pause -> state=2, enable=0. Press again -> state=1.
- RUNNING with expire_pulse and press pulse in the same cycle -> state=3.
  - alarm_led: high 5, low 5, high 5, low 5.
  - After 20 cycles -> state=0, timer_reset=1.
- ALARM then press clear -> state=0.
- PAUSED, assert resetn=0 mid-cycle -> outputs reach reset values immediately. Holding key_start_pause low across reset release produces no event until released and re-pressed.
